pwm_multi_gen: RTL

- Parametrised multi-channel PWM generator, the successor to the single-channel fixed-period PWM block.
- One shared counter with a programmable period; supports edge-aligned and center-aligned modes.
- Each channel has its own duty and output polarity.
- Period, mode and duty writes go to shadow registers and take effect only at a period boundary, so no glitched or partial periods appear on the pins.
- Sits between the AXI/GPIO register interface and the motor/LED output pins.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 63 ++++++
 rtl/pwm_multi_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types for the multi-channel PWM generator.
//   pwm_mode_e : counter shape (edge-aligned sawtooth or center-aligned triangle)
//   pwm_dir_e  : counter direction, only meaningful in center mode
// -----------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM output: shadow/active duty pair, compare against the shared counter,
// polarity inversion and the output register.
//
// Ports
//   clk       : clock
//   reset     : synchronous, active-low reset
//   enable    : 1 = running, 0 = output parked at its inactive level
//   boundary  : shared counter is at the start of a period this cycle
//   cnt       : shared counter value
//   duty_in   : new duty value for this channel
//   duty_wr   : 1-cycle strobe capturing duty_in into the shadow
//   polarity  : 1 = active-low pin
//   pwm_out   : registered PWM output
// -----------------------------------------------------------------------------
module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_wr,
  input  logic             polarity,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CNT_W-1:0] duty_eff;
  logic             raw;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_sh_d = duty_wr ? duty_in : duty_sh_q;
    // At a boundary the freshly written (or shadowed) duty governs the period
    // that starts right now, so it bypasses the active register.
    duty_eff  = boundary ? duty_sh_d : duty_act_q;
    // While disabled the active copy tracks the shadow so nothing stale is left
    // when the counter restarts.
    duty_act_d = (boundary || !enable) ? duty_sh_d : duty_act_q;
    raw        = (cnt < duty_eff);
    pwm_d      = enable ? (raw ^ polarity) : polarity;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// -----------------------------------------------------------------------------
// pwm_multi_gen
// Multi-channel PWM generator with one shared counter. Period, mode and duty
// writes are shadowed and only take effect at a period boundary (counter at 0
// while enabled), so the pins never see a partial period.
//
// Ports
//   clk         : clock
//   reset       : synchronous, active-low reset
//   enable      : 1 = run; 0 = counter held at 0, outputs at inactive level
//   mode_in     : 0 = edge-aligned, 1 = center-aligned (captured by period_wr)
//   period_in   : new period P
//   period_wr   : 1-cycle strobe capturing period_in and mode_in
//   duty_in     : packed duties, channel i in [i*CNT_W +: CNT_W]
//   duty_wr     : per-channel duty strobes
//   polarity    : per-channel output inversion (not shadowed)
//   pwm_out     : registered PWM outputs
//   period_tick : 1-cycle pulse aligned with the first output cycle of a period
// -----------------------------------------------------------------------------
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mode_in,
  input  logic [CNT_W-1:0]        period_in,
  input  logic                    period_wr,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic [NUM_CH-1:0]       duty_wr,
  input  logic [NUM_CH-1:0]       polarity,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] period_eff;
  pwm_mode_e        mode_sh_q, mode_sh_d;
  pwm_mode_e        mode_act_q, mode_act_d;
  pwm_mode_e        mode_eff;
  logic             boundary;
  logic             tick_q;

  always_comb begin
    boundary    = enable && (cnt_q == '0);
    period_sh_d = period_wr ? period_in : period_sh_q;
    mode_sh_d   = period_wr ? pwm_mode_e'(mode_in) : mode_sh_q;

    // Same bypass-on-boundary rule as the channel duties.
    period_eff  = boundary ? period_sh_d : period_act_q;
    mode_eff    = boundary ? mode_sh_d : mode_act_q;

    if (boundary || !enable) begin
      period_act_d = period_sh_d;
      mode_act_d   = mode_sh_d;
    end else begin
      period_act_d = period_act_q;
      mode_act_d   = mode_act_q;
    end

    // Default covers disable and edge mode: counter parked/restarting going up.
    // cnt==0 also always forces up, which covers a mode switch at a boundary.
    cnt_d = '0;
    dir_d = DIR_UP;
    if (enable) begin
      if (mode_eff == PWM_EDGE) begin
        cnt_d = (cnt_q >= period_eff) ? '0 : cnt_q + 1'b1;
      end else if (cnt_q == '0) begin
        cnt_d = (period_eff == '0) ? '0 : CNT_W'(1);
      end else if ((dir_q == DIR_UP) && (cnt_q < period_eff)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Reached the top (or already descending): count down towards 0.
        cnt_d = cnt_q - 1'b1;
        dir_d = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      period_sh_q  <= DEF_P;
      period_act_q <= DEF_P;
      mode_sh_q    <= PWM_EDGE;
      mode_act_q   <= PWM_EDGE;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      mode_sh_q    <= mode_sh_d;
      mode_act_q   <= mode_act_d;
      tick_q       <= boundary;
    end
  end

  assign period_tick = tick_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .boundary(boundary),
      .cnt     (cnt_q),
      .duty_in (duty_in[gi*CNT_W +: CNT_W]),
      .duty_wr (duty_wr[gi]),
      .polarity(polarity[gi]),
      .pwm_out (pwm_out[gi])
    );
  end

endmodule
